program_counter_ras: RTL and testbench

Parametrised program counter for the single-cycle/pipelined CPU datapath, successor to the fixed 64-bit counter. It is generalised in address width and instruction size, and adds call/return modes backed by an internal return-address stack (RAS) with full/empty/overflow/underflow reporting, plus a stall input. It sits at the fetch stage: PC_OUT drives instruction memory, and PS/PC_IN come from the control unit and branch-target adder.

---
 rtl/pc_pkg.sv | 21 ++
 rtl/ras_stack.sv | 64 ++++++
 rtl/program_counter_ras.sv | 153 +++++++++++++++
 tb/tb_program_counter_ras.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Package: pc_pkg
// Shared definitions for the fetch-stage program counter with return-address stack.
//   PS_W : width of the PC-select field driven by the control unit
//   ps_e : PC-select encodings (hold, increment, load, relative, call, call-relative,
//          return, reserved)
package pc_pkg;

    localparam int unsigned PS_W = 3;

    typedef enum logic [PS_W-1:0] {
        PS_HOLD  = 3'b000,
        PS_INC   = 3'b001,
        PS_LOAD  = 3'b010,
        PS_REL   = 3'b011,
        PS_CALL  = 3'b100,
        PS_CALLR = 3'b101,
        PS_RET   = 3'b110,
        PS_RSVD  = 3'b111
    } ps_e;

endpackage

// File: rtl/ras_stack.sv
// Module: ras_stack
// Circular LIFO return-address stack. A push while full overwrites the oldest entry
// and keeps the occupancy at RAS_DEPTH. A pop while empty is ignored.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset; empties the stack
//   push      : write push_data as the new top entry
//   pop       : discard the top entry (ignored when empty)
//   push_data : return address to store
//   top       : most recently pushed entry (undefined content when empty)
//   full      : occupancy == RAS_DEPTH
//   empty     : occupancy == 0
module ras_stack
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    // wr_ptr_q points at the slot the next push writes; the top sits one below it.
    // Because the depth is a power of two the pointer wraps naturally, so a push while
    // full lands on the oldest entry.
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  count_q;

    assign full  = (count_q == CNT_W'(RAS_DEPTH));
    assign empty = (count_q == '0);
    assign top   = mem_q[wr_ptr_q - PTR_W'(1)];

    // Storage carries no reset; stale contents are unreachable while count_q is 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (!full) begin
                count_q <= count_q + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            wr_ptr_q <= wr_ptr_q - PTR_W'(1);
            count_q  <= count_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/program_counter_ras.sv
// Module: program_counter_ras
// Fetch-stage program counter with hold/increment/load/relative modes and call/return
// modes backed by an internal return-address stack.
//   clk         : rising-edge clock
//   rst         : synchronous active-high reset (beats stall and PS)
//   stall       : freeze PC and RAS, suppress all pulses
//   PS          : PC select (see pc_pkg::ps_e)
//   PC_IN       : absolute target or two's-complement byte offset
//   PC_OUT      : registered current PC
//   ras_full    : RAS holds RAS_DEPTH entries
//   ras_empty   : RAS holds no entries
//   ras_ovf     : one-cycle pulse after a call made while full
//   ras_unf     : one-cycle pulse after a return made while empty
//   align_fault : one-cycle pulse after a misaligned target was rejected
// Optional feature: define PC_ALIGN_CHECK_EN to reject LOAD/REL/CALL/CALLR targets whose
// low log2(INSTR_BYTES) bits are nonzero; otherwise targets pass through and align_fault
// is tied low.
module program_counter_ras
    import pc_pkg::*;
#(
    parameter int unsigned     ADDR_W      = 64,
    parameter int unsigned     INSTR_BYTES = 4,
    parameter int unsigned     RAS_DEPTH   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [PS_W-1:0]   PS,
    input  logic [ADDR_W-1:0] PC_IN,
    output logic [ADDR_W-1:0] PC_OUT,
    output logic              ras_full,
    output logic              ras_empty,
    output logic              ras_ovf,
    output logic              ras_unf,
    output logic              align_fault
);

    ps_e               ps;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] rel_target;
    logic [ADDR_W-1:0] ras_top;
    logic              push, pop;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              abs_mis, rel_mis;

    assign ps         = ps_e'(PS);
    assign seq_pc     = pc_q + ADDR_W'(INSTR_BYTES);
    assign rel_target = pc_q + PC_IN;

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSTR_BYTES - 1);

    logic align_q;

    assign abs_mis = |(PC_IN & ALIGN_MASK);
    assign rel_mis = |(rel_target & ALIGN_MASK);

    always_ff @(posedge clk) begin
        if (rst) begin
            align_q <= 1'b0;
        end else begin
            align_q <= !stall &&
                       (((ps == PS_LOAD) || (ps == PS_CALL)) && abs_mis ||
                        ((ps == PS_REL) || (ps == PS_CALLR)) && rel_mis);
        end
    end

    assign align_fault = align_q;
`else
    assign abs_mis     = 1'b0;
    assign rel_mis     = 1'b0;
    assign align_fault = 1'b0;
`endif

    always_comb begin
        pc_d  = pc_q;
        push  = 1'b0;
        pop   = 1'b0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (!stall) begin
            unique case (ps)
                PS_HOLD, PS_RSVD: ;
                PS_INC: pc_d = seq_pc;
                PS_LOAD: begin
                    if (!abs_mis) pc_d = PC_IN;
                end
                PS_REL: begin
                    if (!rel_mis) pc_d = rel_target;
                end
                PS_CALL: begin
                    if (!abs_mis) begin
                        push  = 1'b1;
                        ovf_d = ras_full;
                        pc_d  = PC_IN;
                    end
                end
                PS_CALLR: begin
                    if (!rel_mis) begin
                        push  = 1'b1;
                        ovf_d = ras_full;
                        pc_d  = rel_target;
                    end
                end
                PS_RET: begin
                    // Return with nothing stacked falls through to the next instruction.
                    if (ras_empty) begin
                        pc_d  = seq_pc;
                        unf_d = 1'b1;
                    end else begin
                        pc_d = ras_top;
                        pop  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    ras_stack #(
        .ADDR_W   (ADDR_W),
        .RAS_DEPTH(RAS_DEPTH)
    ) u_ras_stack (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .push_data(seq_pc),
        .top      (ras_top),
        .full     (ras_full),
        .empty    (ras_empty)
    );

    assign PC_OUT  = pc_q;
    assign ras_ovf = ovf_q;
    assign ras_unf = unf_q;

endmodule

// File: tb/tb_program_counter_ras.sv
module tb_program_counter_ras;
    import pc_pkg::*;

    localparam int unsigned DEPTH = 8;

    typedef struct {
        logic [63:0] pc;
        logic        full;
        logic        empty;
        logic        ovf;
        logic        unf;
        logic        align;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [2:0]  PS = 3'd0;
    logic [63:0] PC_IN = '0;
    logic [63:0] PC_OUT;
    logic        ras_full, ras_empty, ras_ovf, ras_unf, align_fault;

    int checks = 0;
    int errors = 0;

    exp_t        exp_q[$];
    logic [63:0] m_pc;
    logic [63:0] m_ras[$];   // back = most recent return address

    always #5 clk = ~clk;

    program_counter_ras dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .PS         (PS),
        .PC_IN      (PC_IN),
        .PC_OUT     (PC_OUT),
        .ras_full   (ras_full),
        .ras_empty  (ras_empty),
        .ras_ovf    (ras_ovf),
        .ras_unf    (ras_unf),
        .align_fault(align_fault)
    );

    function automatic bit misaligned(input logic [63:0] t);
`ifdef PC_ALIGN_CHECK_EN
        return (t % 64'd4) != 64'd0;
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: architectural effect of one clock edge.
    function automatic exp_t model(input bit r, input bit s, input logic [2:0] ps,
                                   input logic [63:0] in);
        exp_t        e;
        logic [63:0] t;
        e.ovf = 0; e.unf = 0; e.align = 0;
        if (r) begin
            m_pc = 64'd0;
            m_ras.delete();
        end else if (!s) begin
            case (ps)
                3'd1: m_pc = m_pc + 64'd4;
                3'd2, 3'd3, 3'd4, 3'd5: begin
                    t = (ps == 3'd2 || ps == 3'd4) ? in : m_pc + in;
                    if (misaligned(t)) begin
                        e.align = 1;
                    end else begin
                        if (ps >= 3'd4) begin
                            if (m_ras.size() == DEPTH) begin
                                e.ovf = 1;
                                void'(m_ras.pop_front());
                            end
                            m_ras.push_back(m_pc + 64'd4);
                        end
                        m_pc = t;
                    end
                end
                3'd6: begin
                    if (m_ras.size() == 0) begin
                        e.unf = 1;
                        m_pc  = m_pc + 64'd4;
                    end else begin
                        m_pc = m_ras.pop_back();
                    end
                end
                default: ;
            endcase
        end
        e.pc    = m_pc;
        e.full  = (m_ras.size() == DEPTH);
        e.empty = (m_ras.size() == 0);
        return e;
    endfunction

    task automatic step(input bit r, input bit s, input logic [2:0] ps, input logic [63:0] in);
        @(negedge clk);
        rst   = r;
        stall = s;
        PS    = ps;
        PC_IN = in;
        exp_q.push_back(model(r, s, ps, in));
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
        end
    endtask

    // Monitor: the DUT presents a new state after every edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pc_out", PC_OUT, e.pc);
            check("ras_full", 64'(ras_full), 64'(e.full));
            check("ras_empty", 64'(ras_empty), 64'(e.empty));
            check("ras_ovf", 64'(ras_ovf), 64'(e.ovf));
            check("ras_unf", 64'(ras_unf), 64'(e.unf));
            check("align_fault", 64'(align_fault), 64'(e.align));
        end
    end

    initial begin
        logic [2:0]  ps;
        logic [63:0] in;
        bit          r, s;

        m_pc = '0;
        // Reset, then increments
        step(1, 0, 3'd0, 64'd0);
        repeat (3) step(0, 0, 3'd1, 64'd0);
        // Load and relative
        step(0, 0, 3'd2, 64'd16);
        step(0, 0, 3'd3, 64'd32);
        step(0, 0, 3'd3, 64'hFFFF_FFFF_FFFF_FFF8);
        // Call / call-relative / returns
        step(0, 0, 3'd4, 64'd100);
        step(0, 0, 3'd5, 64'd20);
        step(0, 0, 3'd6, 64'd0);
        step(0, 0, 3'd6, 64'd0);
        // Overflow then underflow
        step(0, 0, 3'd2, 64'h100);
        repeat (9) step(0, 0, 3'd4, 64'h200);
        repeat (9) step(0, 0, 3'd6, 64'd0);
        // Wrap at top of address space
        step(0, 0, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC);
        step(0, 0, 3'd1, 64'd0);
        // Stall with call pending, then return proves RAS untouched
        step(0, 0, 3'd4, 64'd100);
        step(0, 1, 3'd4, 64'h300);
        step(0, 0, 3'd6, 64'd0);
        // Reset wins over stall
        step(0, 0, 3'd4, 64'd100);
        step(1, 1, 3'd4, 64'h300);
        // Misaligned load
        step(0, 0, 3'd2, 64'd18);
        step(0, 0, 3'd0, 64'd0);
        step(0, 0, 3'd7, 64'h40);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            r  = ($urandom_range(0, 99) < 2);
            s  = ($urandom_range(0, 99) < 10);
            ps = 3'($urandom_range(0, 7));
            if (ps == 3'd3 || ps == 3'd5) begin
                in = 64'($urandom_range(0, 511)) - 64'd256;
            end else begin
                in = {32'($urandom), 32'($urandom)};
            end
            if ($urandom_range(0, 3) != 0) in = in & ~64'd3;
            step(r, s, ps, in);
        end

        @(negedge clk);
        PS = 3'd0;
        @(posedge clk);
        #2;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
